// File: rtl/tlp_tx_arb.sv
// TX TLP scheduler: credit check, round-robin grant over P/NP/CPL,
// and one-DW-per-beat sequencing onto the shared TX stream.
module tlp_tx_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [8:0]  req_fmt,
  input  logic [29:0] req_len,
  input  logic [95:0] req_data,
  output logic [2:0]  req_pop,
  output logic [2:0]  gnt,
  input  logic [23:0] fc_hdr_lim,
  input  logic [35:0] fc_dat_lim,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic [23:0] hdr_consumed,
  output logic [35:0] dat_consumed
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [1:0]  win;
  logic [1:0]  win_q;
  logic [1:0]  c1;
  logic [1:0]  c2;
  logic        found;
  logic [10:0] cnt;
  logic [2:0]  elig;
  logic [7:0]  hcons [3];
  logic [11:0] dcons [3];
  logic [11:0] need  [3];
  logic [10:0] beats [3];

  // Fmt[2] only distinguishes prefixes/types; it never affects scheduling.
  logic fmt_unused;
  assign fmt_unused = ^{req_fmt[8], req_fmt[5], req_fmt[2]};

  for (genvar i = 0; i < 3; i++) begin : g_cls
    logic [1:0]  fmt;
    logic [10:0] len;
    logic [10:0] lq;
    logic [7:0]  hd;
    logic [11:0] dd;

    assign fmt = req_fmt[3*i +: 2];
    assign len = (req_len[10*i +: 10] == 10'd0) ? 11'd1024
               : {1'b0, req_len[10*i +: 10]};
    assign lq  = (len + 11'd3) >> 2;
    assign need[i]  = fmt[1] ? {1'b0, lq} : 12'd0;
    assign beats[i] = (fmt[0] ? 11'd4 : 11'd3)
                    + (fmt[1] ? len : 11'd0);
    assign hd = fc_hdr_lim[8*i +: 8] - (hcons[i] + 8'd1);
    assign dd = fc_dat_lim[12*i +: 12] - (dcons[i] + need[i]);
    assign elig[i] = req[i] && (hd <= 8'd128) && (dd <= 12'd2048);
    assign hdr_consumed[8*i +: 8]   = hcons[i];
    assign dat_consumed[12*i +: 12] = dcons[i];
  end

  always_comb begin
    c1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    found = |elig;
    if (elig[rr_ptr])  win = rr_ptr;
    else if (elig[c1]) win = c1;
    else               win = c2;
  end

  assign req_pop = gnt & {3{tx_valid & tx_ready}};
  assign tx_eop  = tx_valid & (cnt == 11'd1);
  assign tx_data = ({32{gnt[0]}} & req_data[31:0])
                 | ({32{gnt[1]}} & req_data[63:32])
                 | ({32{gnt[2]}} & req_data[95:64]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      win_q    <= 2'd0;
      gnt      <= 3'b000;
      tx_valid <= 1'b0;
      tx_sop   <= 1'b0;
      cnt      <= 11'd0;
      for (int i = 0; i < 3; i++) begin
        hcons[i] <= 8'd0;
        dcons[i] <= 12'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= XFER;
            gnt       <= 3'b001 << win;
            win_q     <= win;
            cnt       <= beats[win];
            tx_valid  <= 1'b1;
            tx_sop    <= 1'b1;
            hcons[win] <= hcons[win] + 8'd1;
            dcons[win] <= dcons[win] + need[win];
          end
        end
        XFER: begin
          if (tx_ready) begin
            tx_sop <= 1'b0;
            cnt    <= cnt - 11'd1;
            if (cnt == 11'd1) begin
              state    <= IDLE;
              gnt      <= 3'b000;
              tx_valid <= 1'b0;
              rr_ptr   <= (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_tx_arb.sv
// Bench for tlp_tx_arb: behavioural sources, expected-beat queue,
// credit, round-robin, backpressure, wrap and reset scenarios.
module tb_tlp_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [8:0]  req_fmt;
  logic [29:0] req_len;
  logic [95:0] req_data;
  logic [2:0]  req_pop;
  logic [2:0]  gnt;
  logic [23:0] fc_hdr_lim;
  logic [35:0] fc_dat_lim;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic [23:0] hdr_consumed;
  logic [35:0] dat_consumed;

  tlp_tx_arb dut (
    .clk(clk), .rst(rst), .req(req),
    .req_fmt(req_fmt), .req_len(req_len),
    .req_data(req_data), .req_pop(req_pop),
    .gnt(gnt), .fc_hdr_lim(fc_hdr_lim),
    .fc_dat_lim(fc_dat_lim), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop),
    .hdr_consumed(hdr_consumed),
    .dat_consumed(dat_consumed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  cls;
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int src_idx[3] = '{0, 0, 0};
  int pops[3] = '{0, 0, 0};
  int m_h[3];
  int m_d[3];

  function automatic logic [31:0] dw(int c, int idx);
    return {4'hC, 2'(c), 10'h0, 16'(idx)};
  endfunction

  assign req_data = {dw(2, src_idx[2]), dw(1, src_idx[1]),
                     dw(0, src_idx[0])};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (req_pop[i]) begin
        src_idx[i] <= src_idx[i] + 1;
        pops[i] <= pops[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst && tx_valid && tx_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: data=%h, nothing queued",
                 tx_data);
      end else begin
        e = sb.pop_front();
        if (tx_data !== e.data || tx_sop !== e.sop ||
            tx_eop !== e.eop || gnt !== (3'b001 << e.cls) ||
            req_pop !== (3'b001 << e.cls)) begin
          errors++;
          $display("FAIL beat: got d=%h sop=%b eop=%b gnt=%b pop=%b want d=%h sop=%b eop=%b cls=%0d",
                   tx_data, tx_sop, tx_eop, gnt, req_pop,
                   e.data, e.sop, e.eop, e.cls);
        end
      end
    end
  end

  task automatic set_src(int c, logic [2:0] f, logic [9:0] l);
    req_fmt[3*c +: 3]  = f;
    req_len[10*c +: 10] = l;
  endtask

  task automatic set_ample;
    for (int c = 0; c < 3; c++) begin
      fc_hdr_lim[8*c +: 8]   = 8'(m_h[c] + 100);
      fc_dat_lim[12*c +: 12] = 12'(m_d[c] + 2000);
    end
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      m_h[c] = 0;
      m_d[c] = 0;
    end
  endtask

  task automatic wait_gnt(output int idle);
    int n = 0;
    idle = 0;
    while (gnt !== 3'b000 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    while (gnt === 3'b000 && idle <= 50) begin
      idle++;
      @(posedge clk); #1;
    end
    if (gnt === 3'b000) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: gnt=%b after %0d cycles, want a grant",
               gnt, idle);
    end
  endtask

  task automatic push_tlp(int c, logic [2:0] f, logic [9:0] l);
    int len = (l == 10'd0) ? 1024 : int'(l);
    int nb = (f[0] ? 4 : 3) + (f[1] ? len : 0);
    for (int b = 0; b < nb; b++)
      sb.push_back('{cls: 2'(c), data: dw(c, src_idx[c] + b),
                     sop: (b == 0), eop: (b == nb - 1)});
    m_h[c] = (m_h[c] + 1) % 256;
    m_d[c] = (m_d[c] + (f[1] ? (len + 3) / 4 : 0)) % 4096;
  endtask

  task automatic wait_drain;
    int n = 0;
    while ((sb.size() != 0 || tx_valid !== 1'b0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (sb.size() != 0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: %0d beats left tx_valid=%b, want 0 and 0",
               sb.size(), tx_valid);
    end
  endtask

  task automatic do_tlp(int c, logic [2:0] f, logic [9:0] l);
    int idle;
    set_src(c, f, l);
    req[c] = 1'b1;
    wait_gnt(idle);
    req[c] = 1'b0;
    checks++;
    if (gnt !== (3'b001 << c) || idle != 1) begin
      errors++;
      $display("FAIL grant: gnt=%b idle=%0d, want %b idle=1",
               gnt, idle, 3'b001 << c);
    end
    push_tlp(c, f, l);
    wait_drain();
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (tx_valid !== 1'b0 || gnt !== 3'b000 || req_pop !== 3'b000 ||
        tx_sop !== 1'b0 || tx_eop !== 1'b0 || tx_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b g=%b p=%b s=%b e=%b d=%h, want all 0",
               tx_valid, gnt, req_pop, tx_sop, tx_eop, tx_data);
    end
    checks++;
    if (hdr_consumed !== 24'h0 || dat_consumed !== 36'h0) begin
      errors++;
      $display("FAIL reset_counters: hdr=%h dat=%h, want 0",
               hdr_consumed, dat_consumed);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 3'b000) begin
      errors++;
      $display("FAIL no_credit_idle: gnt=%b, want 000", gnt);
    end
  endtask

  task automatic test_single_write;
    int p0 = pops[0];
    set_ample();
    do_tlp(0, 3'b010, 10'd1);
    checks++;
    if (hdr_consumed[7:0] !== 8'(m_h[0]) ||
        dat_consumed[11:0] !== 12'(m_d[0])) begin
      errors++;
      $display("FAIL single_credits: hdr=%0d dat=%0d, want %0d %0d",
               hdr_consumed[7:0], dat_consumed[11:0], m_h[0], m_d[0]);
    end
    checks++;
    if (pops[0] - p0 != 4) begin
      errors++;
      $display("FAIL single_pops: %0d pops, want 4", pops[0] - p0);
    end
  endtask

  task automatic test_credit_stall;
    int idle;
    set_ample();
    fc_hdr_lim[15:8] = 8'(m_h[1]);
    set_src(1, 3'b000, 10'd5);
    req[1] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 3'b000 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL hdr_stall: gnt=%b v=%b, want 000 0", gnt, tx_valid);
    end
    fc_hdr_lim[15:8] = 8'(m_h[1] + 1);
    wait_gnt(idle);
    req[1] = 1'b0;
    checks++;
    if (gnt !== 3'b010 || idle != 1) begin
      errors++;
      $display("FAIL hdr_release: gnt=%b idle=%0d, want 010 1", gnt, idle);
    end
    push_tlp(1, 3'b000, 10'd5);
    wait_drain();
    set_ample();
    fc_dat_lim[11:0] = 12'(m_d[0] + 1);
    set_src(0, 3'b010, 10'd8);
    req[0] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 3'b000) begin
      errors++;
      $display("FAIL dat_stall: gnt=%b, want 000", gnt);
    end
    fc_dat_lim[11:0] = 12'(m_d[0] + 2);
    wait_gnt(idle);
    req[0] = 1'b0;
    checks++;
    if (gnt !== 3'b001 || idle != 1) begin
      errors++;
      $display("FAIL dat_release: gnt=%b idle=%0d, want 001 1", gnt, idle);
    end
    push_tlp(0, 3'b010, 10'd8);
    wait_drain();
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 0, 1};
    logic [2:0] f[3] = '{3'b010, 3'b000, 3'b011};
    logic [9:0] l[3] = '{10'd2, 10'd7, 10'd3};
    int idle;
    apply_reset();
    set_ample();
    for (int c = 0; c < 3; c++) set_src(c, f[c], l[c]);
    req = 3'b111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(idle);
      if (k == 4) req = 3'b000;
      checks++;
      if (gnt !== (3'b001 << order[k]) || idle != 1) begin
        errors++;
        $display("FAIL rr_%0d: gnt=%b idle=%0d, want %b idle=1",
                 k, gnt, idle, 3'b001 << order[k]);
      end
      push_tlp(order[k], f[order[k]], l[order[k]]);
    end
    wait_drain();
  endtask

  task automatic test_backpressure;
    int idle;
    set_ample();
    set_src(0, 3'b011, 10'd4);
    req[0] = 1'b1;
    wait_gnt(idle);
    req[0] = 1'b0;
    push_tlp(0, 3'b011, 10'd4);
    @(posedge clk);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== sb[0].data ||
          tx_sop !== sb[0].sop || tx_eop !== sb[0].eop ||
          gnt !== 3'b001 || req_pop !== 3'b000) begin
        errors++;
        $display("FAIL stall_%0d: v=%b d=%h s=%b e=%b g=%b p=%b, want 1 %h %b %b 001 000",
                 k, tx_valid, tx_data, tx_sop, tx_eop, gnt, req_pop,
                 sb[0].data, sb[0].sop, sb[0].eop);
      end
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_max_wrap;
    apply_reset();
    for (int n = 0; n < 16; n++) begin
      set_ample();
      fc_dat_lim[35:24] = 12'(m_d[2] + 2048);
      if (n < 15) do_tlp(2, 3'b011, 10'd0);
      else        do_tlp(2, 3'b010, 10'd640);
    end
    checks++;
    if (dat_consumed[35:24] !== 12'd4000) begin
      errors++;
      $display("FAIL pre_wrap: dat=%0d, want 4000", dat_consumed[35:24]);
    end
    fc_dat_lim[35:24] = 12'(m_d[2] + 2048);
    do_tlp(2, 3'b011, 10'd0);
    checks++;
    if (dat_consumed[35:24] !== 12'd160 ||
        hdr_consumed[23:16] !== 8'd17) begin
      errors++;
      $display("FAIL wrap: dat=%0d hdr=%0d, want 160 17",
               dat_consumed[35:24], hdr_consumed[23:16]);
    end
  endtask

  task automatic test_reset_mid;
    int idle;
    set_ample();
    do_tlp(0, 3'b010, 10'd1);
    set_ample();
    set_src(1, 3'b010, 10'd1);
    req[1] = 1'b1;
    wait_gnt(idle);
    req[1] = 1'b0;
    checks++;
    if (gnt !== 3'b010) begin
      errors++;
      $display("FAIL mid_grant: gnt=%b, want 010", gnt);
    end
    push_tlp(1, 3'b010, 10'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b0 || gnt !== 3'b000 || req_pop !== 3'b000 ||
        tx_sop !== 1'b0 || tx_eop !== 1'b0 || tx_data !== 32'h0 ||
        hdr_consumed !== 24'h0 || dat_consumed !== 36'h0) begin
      errors++;
      $display("FAIL mid_reset: v=%b g=%b e=%b hdr=%h dat=%h, want all 0",
               tx_valid, gnt, tx_eop, hdr_consumed, dat_consumed);
    end
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      m_h[c] = 0;
      m_d[c] = 0;
      set_src(c, 3'b000, 10'd1);
    end
    set_ample();
    req = 3'b111;
    wait_gnt(idle);
    req = 3'b000;
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL rr_after_reset: gnt=%b, want 001", gnt);
    end
    push_tlp(0, 3'b000, 10'd1);
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    req_fmt = '0;
    req_len = '0;
    fc_hdr_lim = '0;
    fc_dat_lim = '0;
    tx_ready = 1'b1;
    test_reset();
    test_single_write();
    test_credit_stall();
    test_round_robin();
    test_backpressure();
    test_max_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
